accelerator_vector_differentiation: RTL
=======================================

Name: accelerator_vector_differentiation

Overview:
- Consumer end of the trainer differentiation stream; the trainer stimulus drives it with size, step and element stream.
- Receives a SIZE-element vector one element per handshake and emits the backward difference (x[i] - x[i-1]) scaled by an arithmetic right shift.
- Sits in the trainer datapath between the FNN output stream and the gradient/update stages.
- Signals start, requests each element, and flags completion.

Parameters:
- DATA_SIZE, 64, element and size width in bits (two's complement data).
- SHIFT_SIZE, 6, width of step-shift input; must satisfy 2^SHIFT_SIZE >= DATA_SIZE.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- START  in  1  one-cycle request to begin a vector.
- READY  out  1  one-cycle pulse when the vector is complete.
- SIZE_IN  in  DATA_SIZE  element count, latched at START.
- SHIFT_IN  in  SHIFT_SIZE  step length as log2, latched at START.
- DATA_IN_ENABLE  in  1  DATA_IN valid this cycle.
- DATA_IN  in  DATA_SIZE  input element.
- DATA_ENABLE  out  1  one-cycle request for the next element.
- DATA_OUT_ENABLE  out  1  one-cycle valid for DATA_OUT.
- DATA_OUT  out  DATA_SIZE  differentiated element.

Behaviour:
- Reset (RST=0, async): all outputs 0; state STARTER; index, prev, size_r, shift_r all 0. Reset mid-vector aborts it silently, with no READY.
- FSM states: STARTER, INPUT, ENDER.
- STARTER:
  - On START=1: latch SIZE_IN into size_r and SHIFT_IN into shift_r; clear prev and index.
  - If SIZE_IN=0, go to ENDER.
  - Otherwise pulse DATA_ENABLE for the next cycle and go to INPUT.
  - DATA_IN_ENABLE is ignored in STARTER.
- INPUT:
  - Each cycle with DATA_IN_ENABLE=1 accepts one element. Back-to-back accepts are legal; DATA_ENABLE is advisory.
  - On accept, register DATA_OUT = (DATA_IN - prev) >>> shift_r. Subtraction is modulo 2^DATA_SIZE; the shift is arithmetic (sign-filling).
  - On accept, DATA_OUT_ENABLE=1 for exactly the following cycle. Latency from accept edge to valid output is 1 cycle.
  - On accept, set prev <= DATA_IN.
  - First element uses prev=0.
  - If index = size_r-1, go to ENDER. Otherwise index++ and pulse DATA_ENABLE the next cycle.
- ENDER: READY=1 for one cycle (the cycle after the last DATA_OUT_ENABLE, or 2 cycles after START when size is 0), then go to STARTER.
- START while not in STARTER is ignored, and latched size/shift stay unchanged.
- DATA_OUT holds its last value when DATA_OUT_ENABLE=0.
- SHIFT_IN >= DATA_SIZE gives all-sign-bit results; no error is raised.
- READY and DATA_ENABLE are never high in the same cycle.

Decomposition:
- Shared package accelerator_differentiation_pkg holds:
  - the state enum (STARTER_STATE, INPUT_STATE, ENDER_STATE);
  - SHIFT_SIZE default constant;
  - a pure function for difference-then-arithmetic-shift, reused by the bench model.
- No sub-module: a single FSM plus datapath of about 150-250 lines.

Test Plan (DATA_SIZE=16):
- SIZE=4, SHIFT=0, inputs 5, 8, 8, 3 -> DATA_OUT 0x0005, 0x0003, 0x0000, 0xFFFB, each 1 cycle after accept; READY pulse 1 cycle after the last output.
- SIZE=3, SHIFT=1, inputs 4, 0xFFFC, 0xFFFC -> 0x0002, 0xFFFC, 0x0000 (arithmetic shift: -8>>>1 = -4).
- SIZE=2, SHIFT=0, inputs 0x7FFF then 0x8000 -> 0x7FFF, 0x0001 (modulo wrap, no saturation).
- SIZE=0, START pulse -> no DATA_ENABLE, no DATA_OUT_ENABLE; READY high exactly 2 cycles after START.
- SIZE=4: START re-pulsed after the 2nd element, with SIZE_IN=9 -> ignored; exactly 4 outputs, then READY.
- SIZE=4: RST low after the 2nd element, then released -> all outputs 0 and no READY. A new START with SIZE=1 and input 7 -> output 0x0007 (prev cleared).

Source files
------------

// File: rtl/accelerator_differentiation_pkg.sv
// Shared types and arithmetic for the vector differentiation accelerator.
// The diff_shift helper is the single definition of the output arithmetic.
package accelerator_differentiation_pkg;

  typedef enum logic [1:0] {
    STARTER_STATE,
    INPUT_STATE,
    ENDER_STATE
  } state_t;

  localparam int SHIFT_SIZE_DEF = 6;
  localparam int unsigned CALC_W = 64;

  // Width-generic: the difference wraps at `width` bits, then sign-extends.
  function automatic logic [CALC_W-1:0] diff_shift(
    input logic [CALC_W-1:0] cur,
    input logic [CALC_W-1:0] prev,
    input int unsigned       width,
    input int unsigned       shift
  );
    logic [CALC_W-1:0] d;
    int unsigned pad;
    int unsigned sh;
    d   = cur - prev;
    pad = CALC_W - width;
    d   = d << pad;
    d   = $signed(d) >>> pad;
    sh  = (shift > CALC_W - 1) ? CALC_W - 1 : shift;
    return $signed(d) >>> sh;
  endfunction

endpackage

// File: rtl/accelerator_vector_differentiation.sv
// Streaming backward difference x[i]-x[i-1], arithmetically shifted.
// One FSM: STARTER latches size/shift, INPUT consumes, ENDER pulses READY.
module accelerator_vector_differentiation
  import accelerator_differentiation_pkg::*;
#(
  parameter int DATA_SIZE  = 64,
  parameter int SHIFT_SIZE = SHIFT_SIZE_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic                  READY,
  input  logic [DATA_SIZE-1:0]  SIZE_IN,
  input  logic [SHIFT_SIZE-1:0] SHIFT_IN,
  input  logic                  DATA_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]  DATA_IN,
  output logic                  DATA_ENABLE,
  output logic                  DATA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]  DATA_OUT
);

  state_t                state, state_n;
  logic [DATA_SIZE-1:0]  index, index_n;
  logic [DATA_SIZE-1:0]  prev, prev_n;
  logic [DATA_SIZE-1:0]  size_r, size_n;
  logic [SHIFT_SIZE-1:0] shift_r, shift_n;
  logic [DATA_SIZE-1:0]  dout_n;
  logic                  doe_n;
  logic                  de_n;
  logic                  ready_n;
  logic [DATA_SIZE-1:0]  diff;

  assign diff = DATA_SIZE'(diff_shift(
    CALC_W'(DATA_IN), CALC_W'(prev), DATA_SIZE, 32'(shift_r)));

  always_comb begin
    state_n = state;
    index_n = index;
    prev_n  = prev;
    size_n  = size_r;
    shift_n = shift_r;
    dout_n  = DATA_OUT;
    doe_n   = 1'b0;
    de_n    = 1'b0;
    ready_n = 1'b0;
    unique case (state)
      STARTER_STATE: begin
        if (START) begin
          size_n  = SIZE_IN;
          shift_n = SHIFT_IN;
          prev_n  = '0;
          index_n = '0;
          if (SIZE_IN == '0) begin
            state_n = ENDER_STATE;
          end else begin
            de_n    = 1'b1;
            state_n = INPUT_STATE;
          end
        end
      end
      INPUT_STATE: begin
        if (DATA_IN_ENABLE) begin
          dout_n = diff;
          doe_n  = 1'b1;
          prev_n = DATA_IN;
          if (index == size_r - DATA_SIZE'(1)) begin
            state_n = ENDER_STATE;
          end else begin
            index_n = index + DATA_SIZE'(1);
            de_n    = 1'b1;
          end
        end
      end
      ENDER_STATE: begin
        ready_n = 1'b1;
        state_n = STARTER_STATE;
      end
      default: state_n = STARTER_STATE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state           <= STARTER_STATE;
      index           <= '0;
      prev            <= '0;
      size_r          <= '0;
      shift_r         <= '0;
      DATA_OUT        <= '0;
      DATA_OUT_ENABLE <= 1'b0;
      DATA_ENABLE     <= 1'b0;
      READY           <= 1'b0;
    end else begin
      state           <= state_n;
      index           <= index_n;
      prev            <= prev_n;
      size_r          <= size_n;
      shift_r         <= shift_n;
      DATA_OUT        <= dout_n;
      DATA_OUT_ENABLE <= doe_n;
      DATA_ENABLE     <= de_n;
      READY           <= ready_n;
    end
  end

endmodule
